pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/halt sequencer for the 5-stage pipeline. Consumes the load-use bubble request from the forwarding unit, branch resolution and mispredict from EX, and halt from EX. Drives PC and pipeline-register enables and clears, runs a RUN/HALT state machine, and keeps performance counters for the prediction-accuracy display.

Parameters:
CNT_W, 32, width of each performance counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
go  in  1  resume pulse; only honoured in HALT
bubble  in  1  load-use hazard from the forwarding unit (ID depends on a load in EX)
br_valid_ex  in  1  conditional branch resolved in EX this cycle
br_mispredict  in  1  EX outcome/target differs from the prediction; ignored unless br_valid_ex
halt_ex  in  1  halt/syscall instruction in EX
pc_en  out  1  PC write enable
pc_redirect  out  1  select the EX-computed correct PC
ifid_en  out  1  IF/ID register enable
ifid_clr  out  1  IF/ID register clear (insert NOP)
idex_clr  out  1  ID/EX register clear (insert NOP)
halted  out  1  state == HALT
cycle_cnt  out  CNT_W  RUN cycles
stall_cnt  out  CNT_W  applied load-use stall cycles
branch_cnt  out  CNT_W  resolved conditional branches
miss_cnt  out  CNT_W  mispredicted branches

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- States are RUN and HALT. The reset state is RUN.
- Define mis = br_valid_ex & br_mispredict.
- Control outputs are combinational from the inputs and the current state, and take effect in the same cycle. State and counters update on the next rising edge.
- While rst=1:
  - pc_en=0, ifid_en=0, ifid_clr=1, idex_clr=1, pc_redirect=0.
  - Next state is RUN and all counters go to 0, including when reset arrives mid-HALT.
- HALT:
  - All enables are 0, all clears and pc_redirect are 0, and counters are frozen.
  - go=1 moves to RUN on the next edge.
  - bubble, br_* and halt_ex are ignored.
- RUN, priority highest first:
  1. halt_ex=1:
     - pc_en=0, ifid_en=0, idex_clr=0, ifid_clr=0. The halt instruction completes and younger instructions stay frozen.
     - Next state is HALT.
     - If mis is also 1, the halt wins and miss_cnt/branch_cnt do not count. halt_ex together with br_valid_ex is architecturally illegal; this rule only makes it deterministic.
  2. mis=1:
     - pc_en=1, pc_redirect=1, ifid_en=1, ifid_clr=1, idex_clr=1. The two wrong-path instructions are squashed.
     - A simultaneous bubble is overridden, because the dependent instruction is wrong-path. stall_cnt does not increment.
  3. bubble=1:
     - pc_en=0, ifid_en=0, idex_clr=1. One NOP is inserted and IF/ID holds.
     - stall_cnt increments.
  4. Otherwise: pc_en=1, ifid_en=1, all clears and pc_redirect are 0.
- A correctly predicted branch (br_valid_ex=1, br_mispredict=0) uses the normal or bubble rule.
- go while in RUN is ignored.
- Counters, while in RUN only:
  - cycle_cnt increments every RUN cycle, including the halt_ex cycle.
  - branch_cnt increments when br_valid_ex=1 and halt_ex=0.
  - miss_cnt increments when mis=1 and halt_ex=0.
  - All counters wrap from 2^CNT_W-1 to 0 without saturation.
- halted is registered: it is 1 from the edge after halt_ex through the edge on which go is accepted.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (ST_RUN, ST_HALT);
  - the default CNT_W;
  - a struct bundling {pc_en, pc_redirect, ifid_en, ifid_clr, idex_clr} for reuse by the top level.
- One sub-module, perf_counter: a CNT_W-wide counter with synchronous clear and an enable, which wraps. It is instantiated four times.

Test Plan:
1. Reset then idle, no hazards, 10 cycles. Expected: pc_en=1 and ifid_en=1 every cycle; cycle_cnt=10; other counters 0; halted=0.
2. bubble=1 for one cycle. Expected: that cycle pc_en=0, ifid_en=0, idex_clr=1; stall_cnt=1 after the edge; the next cycle returns to normal.
3. br_valid_ex=1, br_mispredict=1, bubble=1 in the same cycle. Expected: pc_redirect=1, ifid_clr=1, idex_clr=1, pc_en=1; stall_cnt=0; branch_cnt=1; miss_cnt=1.
4. br_mispredict=1 with br_valid_ex=0. Expected: no flush and no count. Then 3 correct branches give branch_cnt=3 and miss_cnt=0.
5. Halt and resume. Stimulus: halt_ex pulse, 5 idle cycles, go pulse. Expected:
   - halted=1 for 5 cycles with all enables 0 and cycle_cnt frozen;
   - after go, RUN resumes and pc_en=1;
   - go asserted while in RUN has no effect.
6. Reset mid-operation. Stimulus: rst asserted while in HALT with counters at nonzero values. Expected: next cycle is RUN with all counters 0. A separate run with CNT_W=4 forced through 16 cycles shows cycle_cnt wrapping 15 to 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: run/halt state, counter width
// and the bundle of PC / pipeline-register control strobes.
package pipe_ctrl_pkg;

  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic pc_redirect;
    logic ifid_en;
    logic ifid_clr;
    logic idex_clr;
  } ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Free-running performance counter with synchronous clear and count enable;
// wraps to zero on overflow.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage pipeline, with RUN/HALT state and
// performance counters for prediction-accuracy reporting.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             bubble,
  input  logic             br_valid_ex,
  input  logic             br_mispredict,
  input  logic             halt_ex,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  state_t state;
  ctrl_t  ctrl;
  logic   mis;
  logic   run;
  logic   stall_en;
  logic   branch_en;
  logic   miss_en;

  assign mis = br_valid_ex & br_mispredict;
  assign run = (state == ST_RUN) & ~rst;

  // Priority: reset, halt state, halt_ex, mispredict flush, load-use bubble, normal flow.
  always_comb begin
    ctrl = '0;
    if (rst) begin
      ctrl.ifid_clr = 1'b1;
      ctrl.idex_clr = 1'b1;
    end else if (state == ST_RUN) begin
      if (halt_ex) begin
        ctrl = '0;
      end else if (mis) begin
        ctrl = '1;
      end else if (bubble) begin
        ctrl.idex_clr = 1'b1;
      end else begin
        ctrl.pc_en   = 1'b1;
        ctrl.ifid_en = 1'b1;
      end
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign pc_redirect = ctrl.pc_redirect;
  assign ifid_en     = ctrl.ifid_en;
  assign ifid_clr    = ctrl.ifid_clr;
  assign idex_clr    = ctrl.idex_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt_ex) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end
        end
        ST_HALT: begin
          if (go) begin
            state  <= ST_RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= ST_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // A halting instruction suppresses branch accounting and wins over any stall.
  assign stall_en  = run & ~halt_ex & ~mis & bubble;
  assign branch_en = run & ~halt_ex & br_valid_ex;
  assign miss_en   = run & ~halt_ex & mis;

  perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (run),
    .count (cycle_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (stall_en),
    .count (stall_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (branch_en),
    .count (branch_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (miss_en),
    .count (miss_cnt)
  );

endmodule
